branch_resolve_queue: RTL
=========================

Name: branch_resolve_queue

Overview:
- In-order tracker for in-flight branch predictions, sitting between fetch (the predictor consumer) and execute (branch resolution).
- Fetch pushes the PC and predicted direction of each branch. Execute returns actual outcomes in program order.
- The block pops the oldest entry and drives the predictor training interface (valid/pc/taken).
- It flags mispredictions and squashes all younger wrong-path entries.

Parameters:
- DEPTH, 8, queue entries (power of 2, >=2)
- PC_W, 8, PC/index width; matches the predictor table index
- RECOVER_CYC, 2, cycles push_ready stays low after a mispredict (1..15)
- CNT_W, 16, width of statistics counters (optional feature only)

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- push_valid  in  1  fetch presents a predicted branch
- push_ready  out  1  queue accepts a push this cycle
- push_pc  in  PC_W  branch PC
- push_pred  in  1  predicted direction (1 = taken)
- res_valid  in  1  execute presents the outcome of the oldest unresolved branch
- res_taken  in  1  actual direction
- upd_valid  out  1  training pulse to predictor (drives branch_valid)
- upd_pc  out  PC_W  PC to train
- upd_taken  out  1  actual outcome to train with
- mispredict  out  1  one-cycle pulse, coincident with upd_valid
- mp_pc  out  PC_W  PC of the mispredicted branch, valid while mispredict=1
- res_err  out  1  one-cycle pulse: resolve arrived with queue empty or in RECOVER
- occupancy  out  $clog2(DEPTH+1)  entries currently held

Behaviour:
- Storage: circular buffer with rd/wr pointers of $clog2(DEPTH) bits that wrap modulo DEPTH. occupancy is a separate counter, 0..DEPTH.
- FSM has two states, RUN and RECOVER. Reset enters RUN.
- Reset: pointers=0, occupancy=0, state=RUN, recover counter=0. upd_valid, upd_pc, upd_taken, mispredict, mp_pc and res_err all read 0.
- push_ready = (state==RUN) && (occupancy<DEPTH). This is combinational from registered state only.
- No full-queue bypass: a push is refused when full, even if a pop happens the same cycle.
- Push fires on push_valid && push_ready: writes {push_pc, push_pred} at wr_ptr, then wr_ptr+1.
- Resolve fires on res_valid && state==RUN && occupancy>0. It reads the head entry and increments rd_ptr.
- Registered outputs, 1-cycle latency, on the cycle after a resolve fires:
  - upd_valid=1, upd_pc=head.pc, upd_taken=res_taken
  - mispredict=(head.pred != res_taken)
  - mp_pc=head.pc when mispredicting, else 0
- All output pulses are otherwise 0. upd_pc and upd_taken hold their last value when upd_valid=0.
- Correct prediction: pop only.
  - Simultaneous push and pop: occupancy unchanged, both pointers advance.
- Mispredict, at the resolving edge:
  - rd_ptr advances, then wr_ptr is set to the new rd_ptr and occupancy=0, squashing all younger entries.
  - A push firing in the same cycle is discarded (wrong path).
  - The FSM enters RECOVER with the counter loaded with RECOVER_CYC.
- RECOVER:
  - push_ready=0; the counter decrements each cycle.
  - Returns to RUN on the edge where the counter reaches 0, so push_ready is low for exactly RECOVER_CYC cycles starting the cycle after the mispredict edge.
- res_valid with occupancy==0, or in RECOVER: no pop, no update; res_err=1 on the next cycle.
- Asynchronous reset mid-operation: all entries are dropped immediately, outputs go to reset values, and no pending update pulse is emitted.

Optional Feature:
- Macro BRQ_STATS_EN.
- Defined: adds outputs stat_branches[CNT_W-1:0] and stat_mispred[CNT_W-1:0], both cleared by reset.
  - stat_branches increments on each fired resolve; stat_mispred increments on each mispredict.
  - Both saturate at all-ones. Values are visible the cycle after the event, together with upd_valid.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Push pc=0x10 pred=1, pc=0x14 pred=0; resolve taken, then not-taken -> two upd_valid pulses (0x10/1, 0x14/0) one cycle after each resolve, mispredict=0, occupancy 2->1->0.
- Push 8 entries -> push_ready=0 at occupancy=8. Push held with simultaneous resolve -> push refused, occupancy 7. Next cycle push accepted -> occupancy 8.
- Push 0x20 pred=0, 0x24, 0x28; resolve taken -> next cycle upd_valid=1, mispredict=1, mp_pc=0x20, occupancy=0. push_ready low for exactly 2 cycles. A push on the resolve cycle is discarded.
- res_valid with empty queue -> res_err=1 next cycle, upd_valid=0, pointers unchanged. Same result for res_valid during RECOVER.
- Pointer wrap: 20 push/resolve pairs with DEPTH=8 -> every upd_pc matches its push order, no spurious mispredict.
- Assert reset with 3 entries held and a resolve in flight -> occupancy=0 and upd_valid=0 immediately; with BRQ_STATS_EN, both counters read 0.

Source files
------------

// File: rtl/branch_resolve_queue.sv
// branch_resolve_queue: in-order tracker of in-flight branch predictions.
// Fetch pushes {pc, predicted direction}; execute resolves the oldest entry
// in program order. Each resolve drives one predictor training pulse; a
// mispredict squashes every younger entry and blocks fetch for RECOVER_CYC
// cycles.
// Optional statistics counters are enabled with the macro BRQ_STATS_EN.
//
//   state   | meaning
//   RUN     | normal operation, pushes and resolves accepted
//   RECOVER | wrong-path flush in progress, pushes and resolves refused
module branch_resolve_queue #(
  parameter int DEPTH       = 8,
  parameter int PC_W        = 8,
  parameter int RECOVER_CYC = 2,
  parameter int CNT_W       = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push_valid,
  output logic                         push_ready,
  input  logic [PC_W-1:0]              push_pc,
  input  logic                         push_pred,
  input  logic                         res_valid,
  input  logic                         res_taken,
  output logic                         upd_valid,
  output logic [PC_W-1:0]              upd_pc,
  output logic                         upd_taken,
  output logic                         mispredict,
  output logic [PC_W-1:0]              mp_pc,
  output logic                         res_err,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
`ifdef BRQ_STATS_EN
  ,
  output logic [CNT_W-1:0]             stat_branches,
  output logic [CNT_W-1:0]             stat_mispred
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH+1);

  typedef enum logic {RUN, RECOVER} state_t;

  state_t          state, state_next;
  logic [AW-1:0]   rd_ptr, wr_ptr, rd_ptr_inc;
  logic [3:0]      rec_cnt;
  logic [PC_W:0]   mem [DEPTH];
  logic [PC_W:0]   head;
  logic [PC_W-1:0] head_pc;
  logic            head_pred;
  logic            push_fire, res_fire, res_bad, mp_fire;

  assign push_ready = (state == RUN) && (occupancy < OW'(DEPTH));
  assign push_fire  = push_valid && push_ready;
  assign res_fire   = res_valid && (state == RUN) && (occupancy != '0);
  assign res_bad    = res_valid && !res_fire;
  assign head       = mem[rd_ptr];
  assign head_pc    = head[PC_W:1];
  assign head_pred  = head[0];
  assign mp_fire    = res_fire && (head_pred != res_taken);
  assign rd_ptr_inc = rd_ptr + AW'(1);

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RUN;
    else       state <= state_next;
  end

  // FSM next state: leave RECOVER on the edge where the counter hits zero
  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (mp_fire) state_next = RECOVER;
      RECOVER: if (rec_cnt <= 4'd1) state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  // recovery down-counter, loaded on mispredict
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                              rec_cnt <= '0;
    else if (mp_fire)                       rec_cnt <= 4'(RECOVER_CYC);
    else if (state == RECOVER && rec_cnt != '0) rec_cnt <= rec_cnt - 4'd1;
  end

  // entry storage; stale contents are harmless since pointers gate access
  always_ff @(posedge clk) begin
    if (push_fire && !mp_fire) mem[wr_ptr] <= {push_pc, push_pred};
  end

  // pointers and occupancy; a mispredict flushes everything younger than head
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      occupancy <= '0;
    end else if (mp_fire) begin
      rd_ptr    <= rd_ptr_inc;
      wr_ptr    <= rd_ptr_inc;
      occupancy <= '0;
    end else begin
      if (res_fire)  rd_ptr <= rd_ptr_inc;
      if (push_fire) wr_ptr <= wr_ptr + AW'(1);
      case ({push_fire, res_fire})
        2'b10:   occupancy <= occupancy + OW'(1);
        2'b01:   occupancy <= occupancy - OW'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

  // registered training / mispredict / error outputs, one cycle after resolve
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      upd_valid  <= 1'b0;
      upd_pc     <= '0;
      upd_taken  <= 1'b0;
      mispredict <= 1'b0;
      mp_pc      <= '0;
      res_err    <= 1'b0;
    end else begin
      upd_valid  <= res_fire;
      mispredict <= mp_fire;
      mp_pc      <= mp_fire ? head_pc : '0;
      res_err    <= res_bad;
      if (res_fire) begin
        upd_pc    <= head_pc;
        upd_taken <= res_taken;
      end
    end
  end

`ifdef BRQ_STATS_EN
  // saturating resolve / mispredict statistics
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_branches <= '0;
      stat_mispred  <= '0;
    end else begin
      if (res_fire && stat_branches != '1) stat_branches <= stat_branches + CNT_W'(1);
      if (mp_fire && stat_mispred != '1)   stat_mispred  <= stat_mispred + CNT_W'(1);
    end
  end
`endif

endmodule
